// File: rtl/wl_afifo_rd_sched.sv
// rtl/wl_afifo_rd_sched.sv - round-robin read scheduler for N async-FIFO read ports
// Optional stall watchdog is built when WL_RDSCHED_WDT_EN is defined.
module wl_afifo_rd_sched #(
  parameter int N     = 4,
  parameter int IW    = 2,
  parameter int TB    = 2,
  parameter int BURST = 3
`ifdef WL_RDSCHED_WDT_EN
  ,
  parameter int STALL = 15
`endif
) (
  input  logic          i_rclk,
  input  logic          i_rrst_b,
  input  logic [N-1:0]  i_en,
  input  logic [N-1:0]  i_empty,
  input  logic [N-1:0]  i_arempty,
  input  logic [N-1:0]  i_clr_req,
  input  logic          i_dn_ready,
  output logic [N-1:0]  o_rd_en,
  output logic [IW-1:0] o_gnt_id,
  output logic          o_busy,
  output logic [N-1:0]  o_rclr,
  output logic          o_burst_done,
  output logic          o_stall_err
);

  // A burst longer than TB+1 could underflow a FIFO that just left almost-empty.
  localparam int BL = (BURST > TB + 1) ? TB + 1 : ((BURST < 1) ? 1 : BURST);
  localparam int CW = $clog2(BL + 1);

  typedef enum logic [1:0] {ST_ARB, ST_BURST, ST_CLR} state_t;

  state_t        r_state;
  logic [IW-1:0] r_rr_ptr;
  logic [IW-1:0] r_gnt_id;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_clr_pend;
  logic [N-1:0]  r_rclr;
  logic          r_busy;
  logic          r_burst_done;

  logic [N-1:0]  w_pend_nx;
  logic [N-1:0]  w_elig;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_gnt;
  logic          w_found;
  logic [IW-1:0] w_nxt_ptr;
  logic          w_g_abort;
  logic          w_wdt_hit;
  logic          w_abort;
  logic          w_read;

  assign w_pend_nx = r_clr_pend | i_clr_req;
  assign w_elig    = i_en & ~i_empty;
  assign w_nxt_ptr = IW'((int'(r_gnt_id) + 1) % N);

  // Cyclic first-set search over eligible FIFOs starting at the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = IW'((int'(r_rr_ptr) + k) % N);
      if (w_elig[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx;
      end
    end
  end

  assign w_g_abort = r_clr_pend[r_gnt_id] | i_clr_req[r_gnt_id] |
                     ~i_en[r_gnt_id] | i_empty[r_gnt_id];
  assign w_abort   = w_g_abort | w_wdt_hit;
  assign w_read    = (r_state == ST_BURST) && i_dn_ready && !w_abort;
  assign o_rd_en   = w_read ? ({{(N-1){1'b0}}, 1'b1} << r_gnt_id) : '0;

`ifdef WL_RDSCHED_WDT_EN
  localparam int SW = $clog2(STALL + 1);
  logic [SW-1:0] r_stall_cnt;
  logic          r_stall_err;

  // The hit fires on the STALL-th consecutive stalled cycle of a burst.
  assign w_wdt_hit = (r_state == ST_BURST) && !i_dn_ready &&
                     (r_stall_cnt == SW'(STALL - 1));

  // Count stalled burst cycles; any read or leaving BURST restarts the count.
  always_ff @(posedge i_rclk) begin
    if (!i_rrst_b) begin
      r_stall_cnt <= '0;
      r_stall_err <= 1'b0;
    end else begin
      r_stall_err <= w_wdt_hit;
      if (r_state != ST_BURST || w_read || w_wdt_hit)
        r_stall_cnt <= '0;
      else if (!i_dn_ready)
        r_stall_cnt <= r_stall_cnt + SW'(1);
    end
  end

  assign o_stall_err = r_stall_err;
`else
  assign w_wdt_hit   = 1'b0;
  assign o_stall_err = 1'b0;
`endif

  // Main scheduler: arbitrate, run bursts with abort, and issue pending clears.
  always_ff @(posedge i_rclk) begin
    if (!i_rrst_b) begin
      r_state      <= ST_ARB;
      r_rr_ptr     <= '0;
      r_gnt_id     <= '0;
      r_cnt        <= '0;
      r_clr_pend   <= '0;
      r_rclr       <= '0;
      r_busy       <= 1'b0;
      r_burst_done <= 1'b0;
    end else begin
      r_burst_done <= 1'b0;
      r_rclr       <= '0;
      r_clr_pend   <= w_pend_nx;
      case (r_state)
        ST_ARB: begin
          // A clear arriving together with a possible grant takes priority.
          if (|w_pend_nx) begin
            r_state <= ST_CLR;
            r_rclr  <= w_pend_nx;
          end else if (w_found) begin
            r_state  <= ST_BURST;
            r_busy   <= 1'b1;
            r_gnt_id <= w_gnt;
            r_cnt    <= i_arempty[w_gnt] ? CW'(1) : CW'(BL);
          end
        end
        ST_BURST: begin
          if (w_abort) begin
            r_state      <= ST_ARB;
            r_busy       <= 1'b0;
            r_burst_done <= 1'b1;
            r_rr_ptr     <= w_nxt_ptr;
            r_cnt        <= '0;
          end else if (w_read) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
              r_state      <= ST_ARB;
              r_busy       <= 1'b0;
              r_burst_done <= 1'b1;
              r_rr_ptr     <= w_nxt_ptr;
            end
          end
        end
        ST_CLR: begin
          // r_rclr holds the bits issued this cycle; later requests stay pending.
          r_clr_pend <= (r_clr_pend & ~r_rclr) | i_clr_req;
          r_state    <= ST_ARB;
        end
        default: r_state <= ST_ARB;
      endcase
    end
  end

  assign o_gnt_id     = r_gnt_id;
  assign o_busy       = r_busy;
  assign o_rclr       = r_rclr;
  assign o_burst_done = r_burst_done;

endmodule

// File: tb/tb_wl_afifo_rd_sched.sv
// tb/tb_wl_afifo_rd_sched.sv - directed vector bench for wl_afifo_rd_sched
module tb_wl_afifo_rd_sched;

  logic       clk;
  logic       rrst_b;
  logic [3:0] en, empty, arempty, clr_req;
  logic       dn_ready;
  logic [3:0] rd_en;
  logic [1:0] gnt_id;
  logic       busy;
  logic [3:0] rclr;
  logic       burst_done;
  logic       stall_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic       rst_b;
    logic [3:0] en, empty, ar, clr;
    logic       dn;
    logic [3:0] rd;
    logic [1:0] gnt;
    logic       gchk;
    logic       busy;
    logic [3:0] rclr;
    logic       done;
    logic       stall;
  } vec_t;

  vec_t tbl[$];

  wl_afifo_rd_sched dut (
    .i_rclk      (clk),
    .i_rrst_b    (rrst_b),
    .i_en        (en),
    .i_empty     (empty),
    .i_arempty   (arempty),
    .i_clr_req   (clr_req),
    .i_dn_ready  (dn_ready),
    .o_rd_en     (rd_en),
    .o_gnt_id    (gnt_id),
    .o_busy      (busy),
    .o_rclr      (rclr),
    .o_burst_done(burst_done),
    .o_stall_err (stall_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst_b, input logic [3:0] e, input logic [3:0] emp,
                              input logic [3:0] ar, input logic [3:0] clr, input logic dn,
                              input logic [3:0] rd, input logic [1:0] g, input logic b,
                              input logic [3:0] rc, input logic d, input logic s,
                              input logic gforce = 1'b0);
    vec_t v;
    v.rst_b = rst_b; v.en = e; v.empty = emp; v.ar = ar; v.clr = clr; v.dn = dn;
    v.rd = rd; v.gnt = g; v.busy = b; v.rclr = rc; v.done = d; v.stall = s;
    v.gchk = b | gforce;
    return v;
  endfunction

  // Drive one cycle of inputs just after the edge, compare outputs mid-cycle.
  task automatic run(input vec_t v, input string tag);
    logic [1:0] ag, eg;
    rrst_b = v.rst_b; en = v.en; empty = v.empty; arempty = v.ar;
    clr_req = v.clr; dn_ready = v.dn;
    @(negedge clk);
    ag = v.gchk ? gnt_id : 2'd0;
    eg = v.gchk ? v.gnt  : 2'd0;
    total++;
    if ({rd_en, ag, busy, rclr, burst_done, stall_err} !==
        {v.rd, eg, v.busy, v.rclr, v.done, v.stall}) begin
      bad++;
      $display("FAIL %s cyc=%0d got rd=%b gnt=%0d busy=%b rclr=%b done=%b stall=%b want rd=%b gnt=%0d busy=%b rclr=%b done=%b stall=%b",
               tag, cyc, rd_en, ag, busy, rclr, burst_done, stall_err,
               v.rd, eg, v.busy, v.rclr, v.done, v.stall);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] oh;
    int         gl;
    rrst_b = 1'b0; en = 4'hF; empty = 4'h0; arempty = 4'h0; clr_req = 4'h0; dn_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset state, then T1 round-robin over four full FIFOs.
    tbl.push_back(mk(0, 4'hF, 4'h0, 4'h0, 4'h0, 1, 4'h0, 2'd0, 0, 4'h0, 0, 0, 1'b1));
    tbl.push_back(mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 1, 4'h0, 2'd0, 0, 4'h0, 0, 0));
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      for (int r = 0; r < 3; r++)
        tbl.push_back(mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 1, oh, 2'(k % 4), 1, 4'h0, 0, 0));
      if (k < 4)
        tbl.push_back(mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 1, 4'h0, 2'd0, 0, 4'h0, 1, 0));
      else
        tbl.push_back(mk(1, 4'hF, 4'b1011, 4'hF, 4'h0, 1, 4'h0, 2'd0, 0, 4'h0, 1, 0));
    end
    // T2 single reads on FIFO2; empty follows one cycle after each read.
    tbl.push_back(mk(1, 4'hF, 4'b1011, 4'hF, 4'h0, 1, 4'b0100, 2'd2, 1, 4'h0, 0, 0));
    tbl.push_back(mk(1, 4'hF, 4'b1111, 4'hF, 4'h0, 1, 4'h0, 2'd0, 0, 4'h0, 1, 0));
    tbl.push_back(mk(1, 4'hF, 4'b1111, 4'hF, 4'h0, 1, 4'h0, 2'd0, 0, 4'h0, 0, 0));
    tbl.push_back(mk(1, 4'hF, 4'b1011, 4'hF, 4'h0, 1, 4'h0, 2'd0, 0, 4'h0, 0, 0));
    tbl.push_back(mk(1, 4'hF, 4'b1011, 4'hF, 4'h0, 1, 4'b0100, 2'd2, 1, 4'h0, 0, 0));
    tbl.push_back(mk(1, 4'hF, 4'b1111, 4'hF, 4'h0, 1, 4'h0, 2'd0, 0, 4'h0, 1, 0));
    tbl.push_back(mk(1, 4'hF, 4'b1111, 4'hF, 4'h0, 1, 4'h0, 2'd0, 0, 4'h0, 0, 0));

    foreach (tbl[i]) run(tbl[i], (i < 22) ? "t1_rr" : "t2_single");

    // T3 backpressure: FIFO1 burst with a 5-cycle stall after the first read.
    run(mk(1, 4'hF, 4'b1101, 4'h0, 4'h0, 1, 4'h0, 2'd0, 0, 4'h0, 0, 0), "t3_arb");
    run(mk(1, 4'hF, 4'b1101, 4'h0, 4'h0, 1, 4'b0010, 2'd1, 1, 4'h0, 0, 0), "t3_rd1");
    for (int s = 0; s < 5; s++)
      run(mk(1, 4'hF, 4'b1101, 4'h0, 4'h0, 0, 4'h0, 2'd1, 1, 4'h0, 0, 0), "t3_stall");
    run(mk(1, 4'hF, 4'b1101, 4'h0, 4'h0, 1, 4'b0010, 2'd1, 1, 4'h0, 0, 0), "t3_rd2");
    run(mk(1, 4'hF, 4'b1101, 4'h0, 4'h0, 1, 4'b0010, 2'd1, 1, 4'h0, 0, 0), "t3_rd3");

    // T4 clear of the granted FIFO after its first read.
    run(mk(1, 4'hF, 4'b1101, 4'h0, 4'h0, 1, 4'h0, 2'd0, 0, 4'h0, 1, 0), "t4_arb");
    run(mk(1, 4'hF, 4'b1101, 4'h0, 4'h0, 1, 4'b0010, 2'd1, 1, 4'h0, 0, 0), "t4_rd1");
    run(mk(1, 4'hF, 4'b1101, 4'h0, 4'b0010, 1, 4'h0, 2'd1, 1, 4'h0, 0, 0), "t4_abort");
    run(mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 1, 4'h0, 2'd0, 0, 4'h0, 1, 0), "t4_done");
    run(mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 1, 4'h0, 2'd0, 0, 4'b0010, 0, 0), "t4_rclr");
    run(mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 1, 4'h0, 2'd0, 0, 4'h0, 0, 0), "t4_arb2");
    run(mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 1, 4'b0100, 2'd2, 1, 4'h0, 0, 0), "t4_fifo2");

    // T5 reset for one edge mid-burst; next grant restarts at FIFO0.
    run(mk(0, 4'hF, 4'h0, 4'h0, 4'h0, 1, 4'b0100, 2'd2, 1, 4'h0, 0, 0), "t5_rst");
    run(mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 1, 4'h0, 2'd0, 0, 4'h0, 0, 0, 1'b1), "t5_post");
    run(mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 1, 4'b0001, 2'd0, 1, 4'h0, 0, 0), "t5_fifo0");
    run(mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 4'h0, 2'd0, 1, 4'h0, 0, 0), "t5_dis");
    run(mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 4'h0, 2'd0, 0, 4'h0, 1, 0), "t5_done");
    run(mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 4'h0, 2'd0, 0, 4'h0, 0, 0), "t5_idle");

    // T6 twenty stalled cycles in a FIFO1 burst.
    run(mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 0, 4'h0, 2'd0, 0, 4'h0, 0, 0), "t6_arb");
    for (int s = 1; s <= 20; s++) begin
`ifdef WL_RDSCHED_WDT_EN
      if (s <= 15)
        run(mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 0, 4'h0, 2'd1, 1, 4'h0, 0, 0), "t6_stall");
      else if (s == 16)
        run(mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 0, 4'h0, 2'd0, 0, 4'h0, 1, 1), "t6_wdt");
      else
        run(mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 0, 4'h0, 2'd2, 1, 4'h0, 0, 0), "t6_stall2");
`else
      run(mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 0, 4'h0, 2'd1, 1, 4'h0, 0, 0), "t6_stall");
`endif
    end
`ifdef WL_RDSCHED_WDT_EN
    gl = 2;
`else
    gl = 1;
`endif
    oh = 4'b0001 << gl;
    for (int r = 0; r < 3; r++)
      run(mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 1, oh, 2'(gl), 1, 4'h0, 0, 0), "t6_rd");
    run(mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 4'h0, 2'd0, 0, 4'h0, 1, 0), "t6_done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
